sipo_deserializer: RTL and testbench
====================================

Name:
sipo_deserializer

Overview:
Parametrised serial-in/parallel-out deserializer. It is the successor to the fixed 4-bit SIPO shift register. It shifts in one bit per enabled clock and counts bits to frame WIDTH-bit words. Each completed word is presented on a registered parallel output with a valid/ready handshake and sticky overrun detection. It sits between a serial bit source (UART/SPI-style front end) and word-oriented downstream logic.

Parameters:
WIDTH, 8, word length in bits; legal range >= 2.
MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0].
CW, $clog2(WIDTH), bit counter width. Derived; not for override.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
din  input  1  serial data bit.
din_en  input  1  when high, din is sampled on this edge.
clear  input  1  synchronous discard of any partial word and of the overrun flag.
dout  output  WIDTH  last completed word, registered.
dout_valid  output  1  dout holds a word not yet accepted.
dout_ready  input  1  downstream accepts dout when this and dout_valid are both high at an edge.
bit_cnt  output  CW  bits collected in the current partial word, range 0..WIDTH-1.
overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (rst=1 at an edge):
  - dout=0, dout_valid=0, bit_cnt=0, overrun=0, internal shift register=0.
  - rst has priority over every other input.
- Shifting, on an edge with din_en=1 and clear=0:
  - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], din}.
  - MSB_FIRST=0: sh <= {din, sh[WIDTH-1:1]}.
  - bit_cnt increments by 1.
- din_en=0: sh and bit_cnt hold; gaps between bits of any length are legal.
- Word completion:
  - Occurs on an edge with din_en=1, clear=0 and bit_cnt==WIDTH-1.
  - bit_cnt wraps to 0.
  - The completed word, including the bit sampled on this edge, is the load candidate for dout.
  - Latency: dout/dout_valid are visible immediately after the edge that samples the last bit.
- Output handshake, evaluated at each edge. Let acc = dout_valid & dout_ready.
  - Completion with (dout_valid=0 or acc=1): dout <= new word, dout_valid <= 1. Back-to-back words therefore produce no bubble and no overrun.
  - Completion with dout_valid=1 and dout_ready=0: new word dropped, dout and dout_valid hold, overrun <= 1.
  - No completion and acc=1: dout_valid <= 0; dout holds its value. Downstream must not sample dout while dout_valid=0.
  - No completion and acc=0: hold.
- dout is stable whenever dout_valid=1 until the accepting edge.
- clear=1 (rst=0):
  - sh <= 0, bit_cnt <= 0, overrun <= 0.
  - Any din_en in the same cycle is ignored, so no completion occurs.
  - dout and dout_valid are unaffected, and an acceptance in the same cycle still clears dout_valid.
- overrun clears only on rst or clear.
- Reset mid-word: the partial word is lost and a pending dout is lost.
- bit_cnt never exceeds WIDTH-1.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, dout_ready=0. Release rst, shift din 1,1,0,1 on consecutive cycles -> after the 4th edge dout=4'b1101, dout_valid=1, bit_cnt=0. Raise dout_ready for 1 cycle -> dout_valid=0, dout still 4'b1101.
2. WIDTH=4, MSB_FIRST=0, same bits 1,1,0,1 with din_en low for 3 cycles between the 2nd and 3rd bits -> bit_cnt holds at 2 during the gap; final dout=4'b1011.
3. WIDTH=4, dout_ready held 1, 8 consecutive bits 1010_0110 -> dout=4'b1010 after edge 4 and 4'b0110 after edge 8; dout_valid stays high only in the cycles holding an unaccepted word (one cycle each); overrun=0.
4. WIDTH=4, dout_ready=0, send two full words 1111 then 0001 -> dout stays 4'b1111, dout_valid=1, overrun=1 after edge 8. Pulse clear -> overrun=0, dout still 4'b1111.
5. WIDTH=4, shift 1,0 then clear=1 together with din_en=1 -> bit_cnt=0. Next 4 bits 0,1,1,0 -> dout=4'b0110, with no leftover bits from before the clear.
6. WIDTH=8, shift 5 bits, then assert rst for 1 cycle while dout_valid=1 -> dout=0, dout_valid=0, bit_cnt=0, overrun=0. A following 8 bits 8'hA5 MSB-first -> dout=8'hA5.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: frames WIDTH-bit words from a gated bit stream and
// presents them on a registered valid/ready output with sticky overrun detection.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_en,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun
);

    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic             accept;

    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        complete = 1'b0;
        accept   = valid_q & dout_ready;
        shifted  = MSB_FIRST ? {sh_q[WIDTH-2:0], din} : {din, sh_q[WIDTH-1:1]};

        // clear wins over din_en, so a clear cycle can never complete a word
        if (clear) begin
            sh_d  = '0;
            cnt_d = '0;
            ovr_d = 1'b0;
        end else if (din_en) begin
            sh_d = shifted;
            if (cnt_q == LastCnt) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // An accept on the completing edge frees the slot, so back-to-back words never bubble
        if (complete && (!valid_q || accept)) begin
            dout_d  = shifted;
            valid_d = 1'b1;
        end else if (complete) begin
            ovr_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign bit_cnt    = cnt_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: three configurations share one stimulus stream and are checked
// against a bit-list reference model plus directed expectations.
module tb_sipo_deserializer;

    logic clk = 1'b0;
    logic rst, din, din_en, clear, dout_ready;

    logic [3:0] d0_dout;
    logic [3:0] d1_dout;
    logic [7:0] d2_dout;
    logic [1:0] d0_cnt, d1_cnt;
    logic [2:0] d2_cnt;
    logic       d0_valid, d1_valid, d2_valid;
    logic       d0_ov, d1_ov, d2_ov;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_w4m (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .clear(clear),
        .dout(d0_dout), .dout_valid(d0_valid), .dout_ready(dout_ready),
        .bit_cnt(d0_cnt), .overrun(d0_ov)
    );
    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_w4l (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .clear(clear),
        .dout(d1_dout), .dout_valid(d1_valid), .dout_ready(dout_ready),
        .bit_cnt(d1_cnt), .overrun(d1_ov)
    );
    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8m (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .clear(clear),
        .dout(d2_dout), .dout_valid(d2_valid), .dout_ready(dout_ready),
        .bit_cnt(d2_cnt), .overrun(d2_ov)
    );

    always #5 clk = ~clk;

    logic [7:0] o_dout[3];
    logic [2:0] o_cnt[3];
    logic       o_valid[3];
    logic       o_ov[3];

    assign o_dout[0]  = {4'b0, d0_dout};
    assign o_dout[1]  = {4'b0, d1_dout};
    assign o_dout[2]  = d2_dout;
    assign o_cnt[0]   = {1'b0, d0_cnt};
    assign o_cnt[1]   = {1'b0, d1_cnt};
    assign o_cnt[2]   = d2_cnt;
    assign o_valid[0] = d0_valid;
    assign o_valid[1] = d1_valid;
    assign o_valid[2] = d2_valid;
    assign o_ov[0]    = d0_ov;
    assign o_ov[1]    = d1_ov;
    assign o_ov[2]    = d2_ov;

    // Reference model: the list of bits received so far, assembled into a word on completion
    int         wk[3] = '{4, 4, 8};
    bit         msbf[3] = '{1'b1, 1'b0, 1'b1};
    bit         bits[3][8];
    int         n[3];
    logic [7:0] m_dout[3];
    logic       m_valid[3];
    logic       m_ov[3];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] word;
            bit         comp;
            bit         acc;
            word = '0;
            comp = 1'b0;
            acc  = m_valid[k] && dout_ready;
            if (rst) begin
                n[k] = 0; m_dout[k] = '0; m_valid[k] = 1'b0; m_ov[k] = 1'b0;
            end else begin
                if (clear) begin
                    n[k] = 0;
                    m_ov[k] = 1'b0;
                end else if (din_en) begin
                    bits[k][n[k]] = din;
                    n[k]++;
                    if (n[k] == wk[k]) begin
                        for (int i = 0; i < wk[k]; i++)
                            word[msbf[k] ? wk[k] - 1 - i : i] = bits[k][i];
                        comp = 1'b1;
                        n[k] = 0;
                    end
                end
                if (comp && (!m_valid[k] || acc)) begin
                    m_dout[k] = word; m_valid[k] = 1'b1;
                end else if (comp) begin
                    m_ov[k] = 1'b1;
                end else if (acc) begin
                    m_valid[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; din_en = 1'b0; clear = 1'b0; din = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        dout_ready = 1'b0;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (o_dout[k] !== 8'h00 || o_valid[k] !== 1'b0 || o_cnt[k] !== 3'd0 ||
                o_ov[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d: dout=%h valid=%b cnt=%0d ovr=%b, expected all zero",
                         k, o_dout[k], o_valid[k], o_cnt[k], o_ov[k]);
            end
        end
    endtask

    task automatic test_msb_first();
        bit pat[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = pat[i]; din_en = 1'b1;
            tick();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (o_dout[k] !== m_dout[k] || o_valid[k] !== m_valid[k] ||
                    o_cnt[k] !== 3'(n[k]) || o_ov[k] !== m_ov[k]) begin
                    n_fail++;
                    $display("FAIL msb_shift dut%0d: got %h/%b/%0d/%b, expected %h/%b/%0d/%b", k,
                             o_dout[k], o_valid[k], o_cnt[k], o_ov[k],
                             m_dout[k], m_valid[k], n[k], m_ov[k]);
                end
            end
        end
        n_tests++;
        if (d0_dout !== 4'b1101 || d0_valid !== 1'b1 || d0_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL msb_word: dout=%b valid=%b cnt=%0d, expected 1101 1 0",
                     d0_dout, d0_valid, d0_cnt);
        end
        din_en = 1'b0; dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        n_tests++;
        if (d0_valid !== 1'b0 || d0_dout !== 4'b1101) begin
            n_fail++;
            $display("FAIL msb_accept: valid=%b dout=%b, expected 0 1101", d0_valid, d0_dout);
        end
    endtask

    task automatic test_lsb_gap();
        bit pat[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        dout_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                din_en = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    din = 1'(g);
                    tick();
                    n_tests++;
                    if (d1_cnt !== 2'd2) begin
                        n_fail++;
                        $display("FAIL gap_hold: cnt=%0d, expected 2", d1_cnt);
                    end
                end
            end
            din = pat[i]; din_en = 1'b1;
            tick();
        end
        din_en = 1'b0;
        n_tests++;
        if (d1_dout !== 4'b1011 || d1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_word: dout=%b valid=%b, expected 1011 1", d1_dout, d1_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit pat[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = pat[i]; din_en = 1'b1;
            tick();
            n_tests++;
            if (d0_valid !== (i == 3 || i == 7) || d0_ov !== 1'b0 ||
                (i == 3 && d0_dout !== 4'b1010) || (i == 7 && d0_dout !== 4'b0110)) begin
                n_fail++;
                $display("FAIL b2b edge%0d: dout=%b valid=%b ovr=%b", i + 1,
                         d0_dout, d0_valid, d0_ov);
            end
        end
        din_en = 1'b0; dout_ready = 1'b0;
    endtask

    task automatic test_overrun();
        bit pat[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din = pat[i]; din_en = 1'b1;
            tick();
        end
        din_en = 1'b0;
        n_tests++;
        if (d0_dout !== 4'b1111 || d0_valid !== 1'b1 || d0_ov !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: dout=%b valid=%b ovr=%b, expected 1111 1 1",
                     d0_dout, d0_valid, d0_ov);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_tests++;
        if (d0_ov !== 1'b0 || d0_dout !== 4'b1111 || d0_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_clear: ovr=%b dout=%b valid=%b, expected 0 1111 1",
                     d0_ov, d0_dout, d0_valid);
        end
    endtask

    task automatic test_clear();
        bit pat[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        dout_ready = 1'b0;
        din_en = 1'b1;
        din = 1'b1; tick();
        din = 1'b0; tick();
        din = 1'b1; clear = 1'b1; tick();
        clear = 1'b0;
        n_tests++;
        if (d0_cnt !== 2'd0 || d2_cnt !== 3'd0 || d0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_cnt: cnt=%0d/%0d valid=%b, expected 0/0 0",
                     d0_cnt, d2_cnt, d0_valid);
        end
        for (int i = 0; i < 4; i++) begin
            din = pat[i];
            tick();
        end
        din_en = 1'b0;
        n_tests++;
        if (d0_dout !== 4'b0110 || d0_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_word: dout=%b valid=%b, expected 0110 1", d0_dout, d0_valid);
        end
    endtask

    task automatic test_reset_midword();
        logic [7:0] a5 = 8'hA5;
        apply_reset();
        dout_ready = 1'b0;
        din_en = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            din = a5[i];
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            din = 1'($urandom_range(0, 1));
            tick();
        end
        n_tests++;
        if (d2_valid !== 1'b1 || d2_cnt !== 3'd5) begin
            n_fail++;
            $display("FAIL pre_reset: valid=%b cnt=%0d, expected 1 5", d2_valid, d2_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (d2_dout !== 8'h00 || d2_valid !== 1'b0 || d2_cnt !== 3'd0 || d2_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL midword_reset: dout=%h valid=%b cnt=%0d ovr=%b, expected 00 0 0 0",
                     d2_dout, d2_valid, d2_cnt, d2_ov);
        end
        for (int i = 7; i >= 0; i--) begin
            din = a5[i];
            tick();
        end
        din_en = 1'b0;
        n_tests++;
        if (d2_dout !== 8'hA5 || d2_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_word: dout=%h valid=%b, expected a5 1", d2_dout, d2_valid);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            rst        = ($urandom_range(0, 149) == 0);
            clear      = ($urandom_range(0, 39) == 0);
            din_en     = ($urandom_range(0, 3) != 0);
            din        = 1'($urandom_range(0, 1));
            dout_ready = ($urandom_range(0, 2) == 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (o_dout[k] !== m_dout[k] || o_valid[k] !== m_valid[k] ||
                    o_cnt[k] !== 3'(n[k]) || o_ov[k] !== m_ov[k]) begin
                    n_fail++;
                    $display("FAIL random c%0d dut%0d: got %h/%b/%0d/%b, expected %h/%b/%0d/%b",
                             c, k, o_dout[k], o_valid[k], o_cnt[k], o_ov[k],
                             m_dout[k], m_valid[k], n[k], m_ov[k]);
                end
            end
        end
        rst = 1'b0; clear = 1'b0; din_en = 1'b0; dout_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; din_en = 1'b0; clear = 1'b0; dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n[k] = 0; m_dout[k] = '0; m_valid[k] = 1'b0; m_ov[k] = 1'b0;
        end
        test_reset();
        test_msb_first();
        test_lsb_gap();
        test_back_to_back();
        test_overrun();
        test_clear();
        test_reset_midword();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
